// File: rtl/pipe_bin_decoder_pkg.sv
// Shared types and decode helper for the pipelined binary-to-one-hot decoder.
package pbd_pkg;

   localparam int PBD_MAX_IN_W  = 8;
   localparam int PBD_MAX_OUT_W = 1 << PBD_MAX_IN_W;

   typedef enum logic [1:0] {
      PBD_EMPTY,
      PBD_ONE,
      PBD_FULL
   } pbd_state_e;

   typedef struct packed {
      logic                     err;
      logic [PBD_MAX_OUT_W-1:0] word;
   } pbd_dec_t;

   // Codes at or above out_w are unmapped: all-zero word plus the error flag.
   function automatic pbd_dec_t onehot_dec(input logic [PBD_MAX_IN_W-1:0] code,
                                           input int unsigned out_w);
      pbd_dec_t res;
      res.err  = 1'b0;
      res.word = '0;
      if ({24'd0, code} < out_w) begin
         res.word[code] = 1'b1;
      end else begin
         res.err = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/pipe_bin_decoder_if.sv
// Handshake bundle for pipe_bin_decoder: code in on one side, one-hot word out on the other.
interface pipe_bin_decoder_if #(
   parameter int IN_W  = 2,
   parameter int OUT_W = 4
);

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_code;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_onehot;
   logic             out_err;

   modport master (
      output in_valid, in_code, out_ready,
      input  in_ready, out_valid, out_onehot, out_err
   );

   modport slave (
      input  in_valid, in_code, out_ready,
      output in_ready, out_valid, out_onehot, out_err
   );

endinterface

// File: rtl/pipe_bin_decoder_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; every output comes straight from a flop.
module pbd_skid_buf
   import pbd_pkg::*;
#(
   parameter int DATA_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   pbd_state_e        state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              accept;
   logic              take;

   assign accept = in_valid && in_ready_q;
   assign take   = out_valid_q && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         PBD_EMPTY: begin
            if (accept) begin
               main_d  = in_data;
               state_d = PBD_ONE;
            end
         end
         PBD_ONE: begin
            if (accept && take) begin
               main_d = in_data;
            end else if (accept) begin
               skid_d  = in_data;
               state_d = PBD_FULL;
            end else if (take) begin
               state_d = PBD_EMPTY;
            end
         end
         PBD_FULL: begin
            if (take) begin
               main_d  = skid_q;
               state_d = PBD_ONE;
            end
         end
         default: state_d = PBD_EMPTY;
      endcase
      // Ready/valid are registered from the next state so neither depends on out_ready.
      in_ready_d  = (state_d != PBD_FULL);
      out_valid_d = (state_d != PBD_EMPTY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= PBD_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;

endmodule

// File: rtl/pipe_bin_decoder.sv
// Registered binary-to-one-hot decoder with skid buffering and unmapped-code flag.
// Optional saturating error counter on port err_cnt, enabled by PBD_ERRCNT_EN.
module pipe_bin_decoder
   import pbd_pkg::*;
#(
   parameter int IN_W     = 2,
   parameter int OUT_W    = 4,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   pipe_bin_decoder_if.slave   bus
`ifdef PBD_ERRCNT_EN
   ,
   output logic [ERRCNT_W-1:0] err_cnt
`endif
);

   logic [PBD_MAX_IN_W-1:0] code_ext;
   pbd_dec_t                dec;
   logic                    dec_err;
   logic [OUT_W:0]          skid_in;
   logic [OUT_W:0]          skid_out;

   assign code_ext = PBD_MAX_IN_W'(bus.in_code[IN_W-1:0]);
   assign dec      = onehot_dec(code_ext, OUT_W);
   // Any bit set above OUT_W also counts as unmapped, so the full word is consumed.
   assign dec_err  = dec.err || ((dec.word >> OUT_W) != '0);
   assign skid_in  = {dec_err, dec.word[OUT_W-1:0]};

   pbd_skid_buf #(
      .DATA_W (OUT_W + 1)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (skid_in),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (skid_out)
   );

   assign bus.out_onehot = skid_out[OUT_W-1:0];
   assign bus.out_err    = skid_out[OUT_W];

`ifdef PBD_ERRCNT_EN
   logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (bus.out_valid && bus.out_ready && bus.out_err && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_bin_decoder.sv
// Scoreboard bench for pipe_bin_decoder (IN_W=2, OUT_W=3) covering reset, decode, backpressure and random traffic.
module tb_pipe_bin_decoder;

   localparam int IN_W     = 2;
   localparam int OUT_W    = 3;
   localparam int ERRCNT_W = 8;

   typedef struct {
      logic [OUT_W-1:0] onehot;
      logic             err;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   exp_t expQ[$];
   int   checkCount = 0;
   int   errorCount = 0;
   logic stalled = 1'b0;
   logic [OUT_W-1:0] lastOnehot = '0;
   logic lastErr = 1'b0;
   int   errModel = 0;

   pipe_bin_decoder_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

`ifdef PBD_ERRCNT_EN
   logic [ERRCNT_W-1:0] err_cnt;
`endif

   pipe_bin_decoder #(
      .IN_W     (IN_W),
      .OUT_W    (OUT_W),
      .ERRCNT_W (ERRCNT_W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave)
`ifdef PBD_ERRCNT_EN
      ,
      .err_cnt (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic exp_t refDecode(input int code);
      exp_t e;
      if (code < OUT_W) begin
         e.onehot = OUT_W'(1) << code;
         e.err    = 1'b0;
      end else begin
         e.onehot = '0;
         e.err    = 1'b1;
      end
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock cycle: drive at the falling edge, compare registered outputs against the model.
   task automatic applyStimulus(input logic valid, input int code, input logic ready);
      exp_t e;
      logic hasWord;
      logic accept;
      @(negedge clk);
      bus.in_valid  = valid;
      bus.in_code   = IN_W'(code);
      bus.out_ready = ready;
      hasWord = (expQ.size() > 0);
      checkOutput("out_valid", bus.out_valid, hasWord);
      checkOutput("in_ready", bus.in_ready, expQ.size() < 2);
`ifdef PBD_ERRCNT_EN
      checkOutput("err_cnt", err_cnt, errModel);
`endif
      if (stalled) begin
         checkOutput("stall_onehot", bus.out_onehot, lastOnehot);
         checkOutput("stall_err", bus.out_err, lastErr);
      end
      accept = valid && (expQ.size() < 2);
      if (hasWord && ready) begin
         e = expQ.pop_front();
         checkOutput("onehot", bus.out_onehot, e.onehot);
         checkOutput("err", bus.out_err, e.err);
         if (e.err && errModel < (1 << ERRCNT_W) - 1) errModel++;
      end
      if (accept) expQ.push_back(refDecode(code));
      stalled    = hasWord && !ready;
      lastOnehot = bus.out_onehot;
      lastErr    = bus.out_err;
   endtask

   task automatic doReset(input int cycles);
      @(negedge clk);
      reset         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_code   = IN_W'(1);
      bus.out_ready = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("rst_out_valid", bus.out_valid, 0);
         checkOutput("rst_onehot", bus.out_onehot, 0);
         checkOutput("rst_err", bus.out_err, 0);
         checkOutput("rst_in_ready", bus.in_ready, 0);
      end
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      expQ.delete();
      stalled  = 1'b0;
      errModel = 0;
      @(posedge clk);
      #1;
      checkOutput("in_ready_after_reset", bus.in_ready, 1);
   endtask

   initial begin
      int pushed;
      int cycles;
      logic v;
      logic r;
      int c;
      bus.in_valid  = 1'b0;
      bus.in_code   = '0;
      bus.out_ready = 1'b0;

      doReset(3);

      for (int k = 0; k < 4; k++) applyStimulus(1'b1, k, 1'b1);
      repeat (2) applyStimulus(1'b0, 0, 1'b1);

      applyStimulus(1'b1, 1, 1'b0);
      applyStimulus(1'b1, 2, 1'b0);
      applyStimulus(1'b1, 0, 1'b0);
      applyStimulus(1'b0, 0, 1'b0);
      checkOutput("bp_hold", bus.out_onehot, 3'b010);
      repeat (3) applyStimulus(1'b0, 0, 1'b1);

      applyStimulus(1'b1, 1, 1'b0);
      applyStimulus(1'b1, 2, 1'b0);
      doReset(1);
      repeat (3) applyStimulus(1'b0, 0, 1'b1);

`ifdef PBD_ERRCNT_EN
      repeat (300) applyStimulus(1'b1, 3, 1'b1);
      repeat (2) applyStimulus(1'b0, 0, 1'b1);
      checkOutput("errcnt_sat", err_cnt, 255);
      applyStimulus(1'b1, 0, 1'b1);
      repeat (2) applyStimulus(1'b0, 0, 1'b1);
      checkOutput("errcnt_mapped", err_cnt, 255);
      doReset(1);
`endif

      pushed = 0;
      cycles = 0;
      while (pushed < 10000 && cycles < 60000) begin
         v = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         c = int'($urandom_range(0, 3));
         if (v && expQ.size() < 2) pushed++;
         applyStimulus(v, c, r);
         cycles++;
      end
      checkOutput("random_words", pushed, 10000);
      repeat (4) applyStimulus(1'b0, 0, 1'b1);
      checkOutput("drained", expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/pipe_bin_decoder.md
Name: pipe_bin_decoder

Overview:
Parameterised, registered binary-to-one-hot decoder with valid/ready handshakes on both sides. It generalises the fixed 2-to-4 combinational decoder to IN_W input bits and OUT_W outputs. It adds explicit detection of unmapped codes and a 2-entry skid buffer, so it can sit between pipeline stages at full throughput. It is used for select/enable fan-out in control paths, e.g. register-file write enables and unit selects.

Parameters:
IN_W, 2, code width; range 1..8
OUT_W, 4, number of one-hot outputs; 1 <= OUT_W <= 2**IN_W
ERRCNT_W, 8, error counter width (only used with PBD_ERRCNT_EN)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle
in_code  input  IN_W  binary code
out_valid  output  1  decoded word valid
out_ready  input  1  downstream accepts the word
out_onehot  output  OUT_W  decoded one-hot word
out_err  output  1  code was unmapped (in_code >= OUT_W)
err_cnt  output  ERRCNT_W  saturating error count (present only with PBD_ERRCNT_EN)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: while reset is high, at every clk edge: out_valid=0, out_onehot=0, out_err=0, both entries emptied, err_cnt=0. in_ready=0 while reset=1. in_ready=1 on the first cycle after reset deasserts.
- Accept: a word is accepted when in_valid && in_ready. The output is taken when out_valid && out_ready.
- Decode is unsigned:
  - in_code < OUT_W: bit in_code of out_onehot =1, all other bits 0, out_err=0.
  - in_code >= OUT_W: out_onehot all zero, out_err=1. No X and no undefined output under any code.
- Latency: exactly 1 cycle from accept to out_valid, when the main register is free. Throughput is 1 word/cycle with out_ready held high.
- Storage: main register (drives the outputs) plus skid register. The state machine is:
  - EMPTY: no words held; out_valid=0.
  - ONE: main register holds a word; out_valid=1.
  - FULL: main and skid both hold words; out_valid=1, in_ready=0.
- Transitions:
  - EMPTY -> ONE on accept.
  - ONE -> ONE on accept together with a take, or on no accept and no take.
  - ONE -> EMPTY on a take with no accept.
  - ONE -> FULL on an accept with no take; the new word goes to skid.
  - FULL -> ONE on a take; skid moves to main, nothing is accepted.
- in_ready is registered as !FULL. It is never combinationally dependent on out_ready.
- Stability: while out_valid && !out_ready, out_onehot and out_err hold constant.
- Ordering: words leave in acceptance order, with no loss and no duplication.
- Reset mid-operation: all held words are discarded at the reset edge, with no partial output afterwards.
- in_code is ignored when in_valid=0.

Optional Feature:
PBD_ERRCNT_EN
- Defined: port err_cnt exists. It increments by 1 on each take with out_err=1 and saturates at 2**ERRCNT_W-1. It is cleared only by reset.
- Undefined: port err_cnt and its counter are absent. out_err behaviour is unchanged.

Decomposition:
- Package pbd_pkg holds:
  - state enum {PBD_EMPTY, PBD_ONE, PBD_FULL};
  - function onehot_dec(code, OUT_W) returning the word and the err flag;
  - constant PBD_MAX_IN_W=8.
- One natural sub-module: pbd_skid_buf, a generic 2-entry valid/ready skid buffer, parameterised by data width (OUT_W+1). The decode itself is done on the input side before the skid buffer.

Test Plan:
1. Reset: reset=1 for 3 cycles with in_valid=1 -> out_valid=0, out_onehot=0, in_ready=0 throughout; in_ready=1 on the cycle after reset falls.
2. IN_W=2, OUT_W=3, out_ready=1, codes 0,1,2,3 back-to-back -> 001/0, 010/0, 100/0, 000/1 (onehot/err), each 1 cycle after its accept, no bubbles.
3. Backpressure: out_ready=0, send codes 1 then 2 -> out_onehot holds 0010 and in_ready falls after the second accept. A third word is not accepted. Raise out_ready -> 0010 then 0100 on consecutive cycles, then in_ready returns to 1.
4. Reset in FULL: assert reset for 1 cycle -> out_valid=0 next cycle, and no stale word appears after release.
5. PBD_ERRCNT_EN, ERRCNT_W=8: 300 unmapped codes taken -> err_cnt=255. A mapped code does not change it.
6. Random in_valid/out_ready (50%), 10000 random codes -> scoreboard match with no loss, duplication or reorder; outputs stable during every stall.
